uart_tx_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that lets NUM_REQ independent requesters share one UART transmitter.
- Selects one pending byte and drives it into the transmitter's DATA_VALID/P_DATA inputs as a single-cycle launch.
- Tracks the transmitter's busy flag through the full frame, then rotates priority.
- Sits between the per-channel byte sources (FIFOs, register-bank writers) and the TX datapath, in the TX clock domain.

---
 rtl/uart_tx_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that lets NUM_REQ byte sources share one
// UART transmitter. One pending byte is launched as a single-cycle
// TX_DATA_VALID/P_DATA pulse. The arbiter then follows TX_BUSY through the
// whole frame and rotates priority past the requester that was served.
//
// Optional feature: define UART_TX_ARB_WDOG_EN to enable a launch watchdog.
// If TX_BUSY does not rise within WDOG_CYCLES cycles of a launch, TO_ERR
// pulses and the arbiter returns to IDLE. Without the macro, the arbiter waits
// indefinitely for TX_BUSY and TO_ERR is tied low.
module uart_tx_arbiter #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_REQ     = 4,
    parameter int WDOG_CYCLES = 16,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            REQ,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
    output logic [NUM_REQ-1:0]            GNT,
    input  logic                          TX_BUSY,
    output logic                          TX_DATA_VALID,
    output logic [DATA_WIDTH-1:0]         TX_P_DATA,
    output logic [ID_W-1:0]               ACTIVE_ID,
    output logic                          FRAME_DONE,
    output logic                          TO_ERR
);

    // Elaboration-time guard on the supported configuration range.
    if (NUM_REQ < 2 || NUM_REQ > 8 || WDOG_CYCLES < 1) begin : g_param_check
        $error("uart_tx_arbiter: NUM_REQ must be 2..8 and WDOG_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        IDLE,       // free; may launch when a request is pending and TX is idle
        WAIT_BUSY,  // launched; waiting for the transmitter to raise busy
        WAIT_DONE   // frame in flight; waiting for busy to fall
    } state_t;

    state_t                  state,     state_nxt;
    logic [ID_W-1:0]         ptr,       ptr_nxt;
    logic [NUM_REQ-1:0]      gnt_q,     gnt_nxt;
    logic                    dv_q,      dv_nxt;
    logic [DATA_WIDTH-1:0]   data_q,    data_nxt;
    logic [ID_W-1:0]         id_q,      id_nxt;
    logic                    done_q,    done_nxt;

`ifdef UART_TX_ARB_WDOG_EN
    localparam int CNT_W = $clog2(WDOG_CYCLES + 1);
    logic [CNT_W-1:0]        wdog_cnt,  wdog_cnt_nxt;
    logic                    to_q,      to_nxt;
`endif

    // Round-robin search result: first pending requester at or after ptr.
    logic                    found;
    logic [ID_W-1:0]         win;
    logic [ID_W:0]           scan_idx;
    // Priority pointer to use after the current frame: one past the granted requester.
    logic [ID_W-1:0]         ptr_after;

    // Scan REQ from ptr upward, wrapping modulo NUM_REQ, and take the first set bit.
    always_comb begin
        // NOTE: every combinationally assigned signal receives a default before any
        //       branch, so no path leaves it unassigned and no latch is inferred.
        found    = 1'b0;
        win      = '0;
        scan_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = {1'b0, ptr} + (ID_W+1)'(i);
            if (scan_idx >= (ID_W+1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
            end
            if (!found && REQ[scan_idx[ID_W-1:0]]) begin
                found = 1'b1;
                win   = scan_idx[ID_W-1:0];
            end
        end
    end

    // Pointer value after the current frame: one past the granted requester, wrapping.
    always_comb begin
        ptr_after = id_q + ID_W'(1);
        if (id_q == ID_W'(NUM_REQ - 1)) begin
            ptr_after = '0;
        end
    end

    // Next state and next registered outputs.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        gnt_nxt   = '0;
        dv_nxt    = 1'b0;
        data_nxt  = data_q;
        id_nxt    = id_q;
        done_nxt  = 1'b0;
`ifdef UART_TX_ARB_WDOG_EN
        wdog_cnt_nxt = wdog_cnt;
        to_nxt       = 1'b0;
`endif
        case (state)
            IDLE: begin
                // A high TX_BUSY here belongs to someone else's frame. Hold off.
                if (found && !TX_BUSY) begin
                    gnt_nxt   = NUM_REQ'(1) << win;
                    dv_nxt    = 1'b1;
                    data_nxt  = REQ_DATA[int'(win)*DATA_WIDTH +: DATA_WIDTH];
                    id_nxt    = win;
                    state_nxt = WAIT_BUSY;
`ifdef UART_TX_ARB_WDOG_EN
                    wdog_cnt_nxt = '0;
`endif
                end
            end
            WAIT_BUSY: begin
                if (TX_BUSY) begin
                    state_nxt = WAIT_DONE;
`ifdef UART_TX_ARB_WDOG_EN
                end else if (wdog_cnt == CNT_W'(WDOG_CYCLES - 1)) begin
                    // The count reaches WDOG_CYCLES at this edge, so give up on this launch.
                    to_nxt    = 1'b1;
                    ptr_nxt   = ptr_after;
                    state_nxt = IDLE;
                end else begin
                    wdog_cnt_nxt = wdog_cnt + CNT_W'(1);
`endif
                end
            end
            WAIT_DONE: begin
                if (!TX_BUSY) begin
                    done_nxt  = 1'b1;
                    ptr_nxt   = ptr_after;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; every output comes straight from a flop.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            ptr    <= '0;
            gnt_q  <= '0;
            dv_q   <= 1'b0;
            data_q <= '0;
            id_q   <= '0;
            done_q <= 1'b0;
`ifdef UART_TX_ARB_WDOG_EN
            wdog_cnt <= '0;
            to_q     <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments make all flops update together from
            //       values sampled at the same edge, matching real hardware.
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            gnt_q  <= gnt_nxt;
            dv_q   <= dv_nxt;
            data_q <= data_nxt;
            id_q   <= id_nxt;
            done_q <= done_nxt;
`ifdef UART_TX_ARB_WDOG_EN
            wdog_cnt <= wdog_cnt_nxt;
            to_q     <= to_nxt;
`endif
        end
    end

    assign GNT           = gnt_q;
    assign TX_DATA_VALID = dv_q;
    assign TX_P_DATA     = data_q;
    assign ACTIVE_ID     = id_q;
    assign FRAME_DONE    = done_q;
`ifdef UART_TX_ARB_WDOG_EN
    assign TO_ERR        = to_q;
`else
    assign TO_ERR        = 1'b0;
`endif

    // Invariants: at most one grant, and a grant always coincides with the launch strobe.
    a_gnt_onehot: assert property (@(posedge CLK) disable iff (RST) $onehot0(gnt_q));
    a_gnt_dv:     assert property (@(posedge CLK) disable iff (RST) (|gnt_q) == dv_q);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter. A transmitter model reacts to launches.
// Randomized frames are compared against a round-robin reference model.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int WD = 16;

    logic            CLK = 1'b0;
    logic            RST;
    logic [N-1:0]    REQ;
    logic [N*DW-1:0] REQ_DATA;
    logic [N-1:0]    GNT;
    logic            TX_BUSY;
    logic            TX_DATA_VALID;
    logic [DW-1:0]   TX_P_DATA;
    logic [1:0]      ACTIVE_ID;
    logic            FRAME_DONE;
    logic            TO_ERR;

    uart_tx_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .WDOG_CYCLES(WD)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_DATA(REQ_DATA), .GNT(GNT),
        .TX_BUSY(TX_BUSY), .TX_DATA_VALID(TX_DATA_VALID), .TX_P_DATA(TX_P_DATA),
        .ACTIVE_ID(ACTIVE_ID), .FRAME_DONE(FRAME_DONE), .TO_ERR(TO_ERR)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    // Transmitter model controls.
    bit auto_tx;
    int rise_delay, busy_len, rise_cnt, hold_cnt, fall_cycle;
    logic [7:0] tx_log[$];

    // Reference model: the priority pointer and the byte each requester presents.
    int m_ptr;
    logic [7:0] bytes [N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    function automatic int rr_pick(input int ptr, input logic [N-1:0] req);
        for (int k = 0; k < N; k++) begin
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // Advance one clock. Sample just after the edge, run the transmitter model, then check invariants.
    task automatic step();
        logic busy_at_edge;
        @(posedge CLK);
        #1;
        cycle++;
        busy_at_edge = TX_BUSY;
        check("gnt_onehot", 32'($countones(GNT) <= 1), 1);
        check("gnt_vs_dv", |GNT, TX_DATA_VALID);
        if (|GNT) check("gnt_while_busy", busy_at_edge, 0);
        if (auto_tx) begin
            if (rise_cnt > 0) begin
                rise_cnt--;
                if (rise_cnt == 0) begin
                    TX_BUSY  = 1'b1;
                    hold_cnt = busy_len;
                end
            end else if (hold_cnt > 0) begin
                hold_cnt--;
                if (hold_cnt == 0) begin
                    TX_BUSY    = 1'b0;
                    fall_cycle = cycle;
                end
            end
        end
        if (TX_DATA_VALID) begin
            tx_log.push_back(TX_P_DATA);
            if (auto_tx) rise_cnt = rise_delay;
        end
    endtask

    task automatic drive_bytes();
        for (int i = 0; i < N; i++) REQ_DATA[i*DW +: DW] = bytes[i];
    endtask

    // One complete frame. Call it with the arbiter idle and TX_BUSY low; req must be non-zero.
    task automatic do_frame(input logic [N-1:0] req, input int rdly, input int blen, input bit scramble);
        int w;
        int done_cycle;
        logic [7:0] exp_byte;
        w          = rr_pick(m_ptr, req);
        exp_byte   = bytes[w];
        rise_delay = rdly;
        busy_len   = blen;
        REQ        = req;
        drive_bytes();
        step();
        check("gnt", GNT, 32'(1) << w);
        check("launch", TX_DATA_VALID, 1);
        check("p_data", TX_P_DATA, exp_byte);
        check("active_id", ACTIVE_ID, w);
        check("done_pulse_width", FRAME_DONE, 0);
        done_cycle = -1;
        for (int k = 0; k < rdly + blen + 6; k++) begin
            if (scramble) begin
                REQ      = N'($urandom);
                REQ_DATA = $urandom;
            end
            step();
            check("no_gnt_in_frame", GNT, 0);
            check("no_to_err", TO_ERR, 0);
            check("id_hold", ACTIVE_ID, w);
            check("data_hold", TX_P_DATA, exp_byte);
            if (FRAME_DONE) begin
                done_cycle = cycle;
                break;
            end
        end
        REQ = '0;
        check("frame_done_seen", done_cycle != -1, 1);
        if (done_cycle != -1) check("done_latency", done_cycle - fall_cycle, 1);
        m_ptr = (w + 1) % N;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w;
        int launch_cycle;
        int evt_cycle;
        logic [7:0] exp_rr [5];

        RST = 1'b1; REQ = '0; REQ_DATA = '0; TX_BUSY = 1'b0;
        auto_tx = 1'b1; rise_cnt = 0; hold_cnt = 0; fall_cycle = 0; m_ptr = 0;
        step();
        step();
        check("rst_gnt", GNT, 0);
        check("rst_dv", TX_DATA_VALID, 0);
        check("rst_pdata", TX_P_DATA, 0);
        check("rst_id", ACTIVE_ID, 0);
        check("rst_done", FRAME_DONE, 0);
        check("rst_to", TO_ERR, 0);
        RST = 1'b0;
        step();

        // Round robin with all requesters held high.
        for (int i = 0; i < N; i++) bytes[i] = 8'h10 + 8'(i);
        exp_rr = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        tx_log.delete();
        for (int f = 0; f < 5; f++) do_frame(4'b1111, 1, $urandom_range(3, 8), 1'b0);
        check("rr_count", tx_log.size(), 5);
        for (int f = 0; f < 5 && f < tx_log.size(); f++) check("rr_order", tx_log[f], exp_rr[f]);

        // A single frame with a 20-cycle busy period.
        bytes[1] = 8'h3C;
        do_frame(4'b0010, 1, 20, 1'b0);
        check("single_id", ACTIVE_ID, 1);

        // Pointer rotation: 2, then 0 (scan 3,0), then 2.
        do_frame(4'b0100, 1, 4, 1'b0);
        check("rot_a", ACTIVE_ID, 2);
        do_frame(4'b0101, 2, 4, 1'b0);
        check("rot_b", ACTIVE_ID, 0);
        do_frame(4'b0101, 1, 3, 1'b0);
        check("rot_c", ACTIVE_ID, 2);

        // Foreign busy in IDLE, then the request is withdrawn.
        auto_tx = 1'b0;
        TX_BUSY = 1'b1;
        REQ     = 4'b1000;
        repeat (5) begin
            step();
            check("busy_idle_no_gnt", GNT, 0);
        end
        REQ = '0;
        step();
        TX_BUSY = 1'b0;
        repeat (5) begin
            step();
            check("withdrawn_no_gnt", GNT, 0);
            check("withdrawn_no_dv", TX_DATA_VALID, 0);
        end
        auto_tx = 1'b1;

        // Randomized frames, back to back, with REQ scrambled while a frame is in flight.
        for (int it = 0; it < 25; it++) begin
            for (int i = 0; i < N; i++) bytes[i] = 8'($urandom);
            do_frame(N'($urandom_range(1, 15)), $urandom_range(1, 3), $urandom_range(1, 12), 1'b1);
        end

        // Launch with TX_BUSY never rising.
        auto_tx = 1'b0;
        TX_BUSY = 1'b0;
        for (int i = 0; i < N; i++) bytes[i] = 8'($urandom);
        REQ = 4'b0010;
        drive_bytes();
        w = rr_pick(m_ptr, REQ);
        step();
        check("stall_gnt", GNT, 32'(1) << w);
        launch_cycle = cycle;
        REQ = '0;
`ifdef UART_TX_ARB_WDOG_EN
        evt_cycle = -1;
        for (int k = 0; k < 40; k++) begin
            step();
            check("wdog_no_done", FRAME_DONE, 0);
            if (TO_ERR) begin
                evt_cycle = cycle;
                break;
            end
        end
        check("wdog_seen", evt_cycle != -1, 1);
        if (evt_cycle != -1) check("wdog_latency", evt_cycle - launch_cycle, WD);
        step();
        check("wdog_pulse_width", TO_ERR, 0);
        m_ptr = (w + 1) % N;
`else
        REQ = 4'b1111;
        repeat (40) begin
            step();
            check("stuck_no_to", TO_ERR, 0);
            check("stuck_no_done", FRAME_DONE, 0);
            check("stuck_no_gnt", GNT, 0);
        end
        REQ = '0;
        TX_BUSY = 1'b1;
        repeat (3) step();
        TX_BUSY = 1'b0;
        launch_cycle = cycle;
        evt_cycle = -1;
        for (int k = 0; k < 5; k++) begin
            step();
            if (FRAME_DONE) begin
                evt_cycle = cycle;
                break;
            end
        end
        check("late_busy_done", evt_cycle - launch_cycle, 1);
        m_ptr = (w + 1) % N;
`endif
        auto_tx = 1'b1;
        step();
        do_frame(4'b1111, 1, 3, 1'b0);
        check("after_stall_next", ACTIVE_ID, (w + 1) % N);

        // Asynchronous reset in the middle of a frame (WAIT_DONE).
        bytes[3] = 8'h5A;
        rise_delay = 1;
        busy_len = 20;
        REQ = 4'b1000;
        drive_bytes();
        w = rr_pick(m_ptr, REQ);
        step();
        check("pre_rst_gnt", GNT, 32'(1) << w);
        REQ = '0;
        repeat (5) step();
        #2;
        RST = 1'b1;
        #1;
        check("mid_rst_gnt", GNT, 0);
        check("mid_rst_dv", TX_DATA_VALID, 0);
        check("mid_rst_pdata", TX_P_DATA, 0);
        check("mid_rst_id", ACTIVE_ID, 0);
        check("mid_rst_done", FRAME_DONE, 0);
        check("mid_rst_to", TO_ERR, 0);
        auto_tx = 1'b0;
        TX_BUSY = 1'b0;
        rise_cnt = 0;
        hold_cnt = 0;
        step();
        step();
        RST = 1'b0;
        m_ptr = 0;
        auto_tx = 1'b1;
        bytes[2] = 8'hA5;
        do_frame(4'b0100, 1, 4, 1'b0);
        check("post_rst_pdata", TX_P_DATA, 8'hA5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
